// File: rtl/key_event_detector.sv
// key_event_detector: N-channel push-button front end producing debounced level and short/long/repeat event pulses
// Ports:
//   CLOCK_50     system clock, rising edge
//   reset        asynchronous active-high reset
//   KEY          raw active-low buttons, asynchronous to CLOCK_50
//   key_level    debounced pressed state (1 = pressed)
//   short_pulse  one-cycle pulse on debounced release of a short press
//   long_pulse   one-cycle pulse when a hold reaches LONG_CYCLES
//   repeat_pulse one-cycle auto-repeat pulses; constant 0 unless KEY_REPEAT_EN is defined
// Build option: define KEY_REPEAT_EN to enable auto-repeat after the long event.
module key_event_detector #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] short_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] repeat_pulse
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] PRESS_DB   = 2'd1;
  localparam logic [1:0] HELD       = 2'd2;
  localparam logic [1:0] RELEASE_DB = 2'd3;
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_db
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("LONG_CYCLES must exceed DEBOUNCE_CYCLES");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_rep
    $error("REPEAT_CYCLES must be >= 2");
  end
  // Synchroniser resets to released so a key held through reset is seen as a fresh press.
  logic [N_KEYS-1:0] s1, ks;
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      s1 <= '1;
      ks <= '1;
    end else begin
      s1 <= KEY;
      ks <= s1;
    end
  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    logic [1:0]    st;
    logic [DW-1:0] db;
    logic [HW-1:0] hold;
    logic          long_done, lvl, sp, lp;
    assign key_level[i]   = lvl;
    assign short_pulse[i] = sp;
    assign long_pulse[i]  = lp;
`ifdef KEY_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    logic [RW-1:0] rep;
    logic          rp;
    assign repeat_pulse[i] = rp;
`else
    assign repeat_pulse[i] = 1'b0;
`endif
    always_ff @(posedge CLOCK_50 or posedge reset)
      if (reset) begin
        st        <= IDLE;
        db        <= '0;
        hold      <= '0;
        long_done <= 1'b0;
        lvl       <= 1'b0;
        sp        <= 1'b0;
        lp        <= 1'b0;
`ifdef KEY_REPEAT_EN
        rep       <= '0;
        rp        <= 1'b0;
`endif
      end else begin
        sp <= 1'b0;
        lp <= 1'b0;
`ifdef KEY_REPEAT_EN
        rp <= 1'b0;
`endif
        case (st)
          IDLE:
            if (!ks[i]) begin
              st <= PRESS_DB;
              db <= DW'(1);
            end
          PRESS_DB:
            if (ks[i]) begin
              st <= IDLE;
              db <= '0;
            end else if (db == DW'(DEBOUNCE_CYCLES - 1)) begin
              st        <= HELD;
              db        <= '0;
              lvl       <= 1'b1;
              hold      <= '0;
              long_done <= 1'b0;
            end else db <= db + 1'b1;
          HELD: begin
            if (hold < HW'(LONG_CYCLES)) hold <= hold + 1'b1;
            if (hold == HW'(LONG_CYCLES - 1) && !long_done) begin
              lp        <= 1'b1;
              long_done <= 1'b1;
            end
`ifdef KEY_REPEAT_EN
            // Counting starts the cycle after the long event, so the first repeat lands REPEAT_CYCLES later.
            if (long_done) begin
              rep <= (rep == RW'(REPEAT_CYCLES - 1)) ? '0 : rep + 1'b1;
              rp  <= rep == RW'(REPEAT_CYCLES - 1);
            end
`endif
            if (ks[i]) begin
              st <= RELEASE_DB;
              db <= DW'(1);
            end
          end
          RELEASE_DB:
            if (!ks[i]) begin
              st <= HELD;
              db <= '0;
            end else if (db == DW'(DEBOUNCE_CYCLES - 1)) begin
              st  <= IDLE;
              db  <= '0;
              lvl <= 1'b0;
              sp  <= !long_done;
`ifdef KEY_REPEAT_EN
              rep <= '0;
`endif
            end else db <= db + 1'b1;
        endcase
      end
  end
endmodule

// File: tb/tb_key_event_detector.sv
// tb_key_event_detector: scoreboard bench for key_event_detector
module tb_key_event_detector;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key;
  logic [3:0] key_level, short_pulse, long_pulse, repeat_pulse;
  logic [3:0] prev_level = '0;
  int cyc = 0, vectors = 0, miscompares = 0;
  logic [31:0] exp_q[$], obs_q[$];
  logic [31:0] e, o;
  always #5 clk = ~clk;
  key_event_detector #(
    .N_KEYS(4), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8)
  ) dut (
    .CLOCK_50(clk), .reset(rst), .KEY(key), .key_level(key_level),
    .short_pulse(short_pulse), .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
  );
  // event word: cycle, kind (1 rise, 2 fall, 3 short, 4 long, 5 repeat), channel mask
  function automatic logic [31:0] ev(int c, int k, logic [3:0] m);
    return {c[23:0], k[3:0], m};
  endfunction
  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
      #1;
      if ((key_level & ~prev_level) != 0) obs_q.push_back(ev(cyc, 1, key_level & ~prev_level));
      if ((~key_level & prev_level) != 0) obs_q.push_back(ev(cyc, 2, ~key_level & prev_level));
      if (short_pulse != 0) obs_q.push_back(ev(cyc, 3, short_pulse));
      if (long_pulse != 0) obs_q.push_back(ev(cyc, 4, long_pulse));
      if (repeat_pulse != 0) obs_q.push_back(ev(cyc, 5, repeat_pulse));
      prev_level = key_level;
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    key = 4'b0000;
    #2;
    vectors++;
    if ({key_level, short_pulse, long_pulse, repeat_pulse} !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_state: got %h want 0000", {key_level, short_pulse, long_pulse, repeat_pulse});
    end
    step(3);
    vectors++;
    if ({key_level, short_pulse, long_pulse, repeat_pulse} !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_held: got %h want 0000", {key_level, short_pulse, long_pulse, repeat_pulse});
    end
    key = 4'b1111;
    step(1);
    rst = 1'b0;
    step(50);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 'x;
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL reset_events: got %h want %h", o, e); end
    end
    vectors++;
    if (obs_q.size() != 0) begin miscompares++; $display("FAIL reset_extra: got %0d events (first %h) want 0", obs_q.size(), obs_q[0]); end
    obs_q.delete();
  endtask
  task automatic test_short;
    int c0 = cyc;
    key[2] = 1'b0;
    exp_q.push_back(ev(c0 + 6, 1, 4'b0100));
    step(12);
    key[2] = 1'b1;
    exp_q.push_back(ev(c0 + 18, 2, 4'b0100));
    exp_q.push_back(ev(c0 + 18, 3, 4'b0100));
    step(15);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 'x;
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL short_events: got %h want %h", o, e); end
    end
    vectors++;
    if (obs_q.size() != 0) begin miscompares++; $display("FAIL short_extra: got %0d events (first %h) want 0", obs_q.size(), obs_q[0]); end
    obs_q.delete();
  endtask
  task automatic test_bounce;
    logic [6:0] pat = 7'b1001000;
    int c0;
    for (int i = 0; i < 7; i++) begin
      key[0] = pat[i];
      step(1);
    end
    key[0] = 1'b1;
    step(20);
    c0 = cyc;
    key[0] = 1'b0;
    exp_q.push_back(ev(c0 + 6, 1, 4'b0001));
    step(10);
    key[0] = 1'b1;
    step(2);
    key[0] = 1'b0;
    step(4);
    key[0] = 1'b1;
    exp_q.push_back(ev(c0 + 22, 2, 4'b0001));
    exp_q.push_back(ev(c0 + 22, 3, 4'b0001));
    step(15);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 'x;
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL bounce_events: got %h want %h", o, e); end
    end
    vectors++;
    if (obs_q.size() != 0) begin miscompares++; $display("FAIL bounce_extra: got %0d events (first %h) want 0", obs_q.size(), obs_q[0]); end
    obs_q.delete();
  endtask
  task automatic test_long;
    int c0 = cyc;
    key[1] = 1'b0;
    exp_q.push_back(ev(c0 + 6, 1, 4'b0010));
    exp_q.push_back(ev(c0 + 26, 4, 4'b0010));
`ifdef KEY_REPEAT_EN
    exp_q.push_back(ev(c0 + 34, 5, 4'b0010));
    exp_q.push_back(ev(c0 + 42, 5, 4'b0010));
`endif
    step(45);
    key[1] = 1'b1;
    exp_q.push_back(ev(c0 + 51, 2, 4'b0010));
    step(15);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 'x;
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL long_events: got %h want %h", o, e); end
    end
    vectors++;
    if (obs_q.size() != 0) begin miscompares++; $display("FAIL long_extra: got %0d events (first %h) want 0", obs_q.size(), obs_q[0]); end
    obs_q.delete();
  endtask
  task automatic test_simultaneous;
    int c0 = cyc;
    key = 4'b0110;
    exp_q.push_back(ev(c0 + 6, 1, 4'b1001));
    step(10);
    key = 4'b1111;
    exp_q.push_back(ev(c0 + 16, 2, 4'b1001));
    exp_q.push_back(ev(c0 + 16, 3, 4'b1001));
    step(15);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 'x;
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL simul_events: got %h want %h", o, e); end
    end
    vectors++;
    if (obs_q.size() != 0) begin miscompares++; $display("FAIL simul_extra: got %0d events (first %h) want 0", obs_q.size(), obs_q[0]); end
    obs_q.delete();
  endtask
  task automatic test_reset_mid;
    int c0 = cyc;
    key[2] = 1'b0;
    exp_q.push_back(ev(c0 + 6, 1, 4'b0100));
    step(16);
    rst = 1'b1;
    #2;
    vectors++;
    if ({key_level, short_pulse, long_pulse, repeat_pulse} !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_mid_async: got %h want 0000", {key_level, short_pulse, long_pulse, repeat_pulse});
    end
    exp_q.push_back(ev(c0 + 17, 2, 4'b0100));
    step(2);
    rst = 1'b0;
    exp_q.push_back(ev(c0 + 24, 1, 4'b0100));
    exp_q.push_back(ev(c0 + 44, 4, 4'b0100));
    step(30);
    key[2] = 1'b1;
    exp_q.push_back(ev(c0 + 54, 2, 4'b0100));
    step(12);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 'x;
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL reset_mid_events: got %h want %h", o, e); end
    end
    vectors++;
    if (obs_q.size() != 0) begin miscompares++; $display("FAIL reset_mid_extra: got %0d events (first %h) want 0", obs_q.size(), obs_q[0]); end
    obs_q.delete();
  endtask
  initial begin
    test_reset;
    test_short;
    test_bounce;
    test_long;
    test_simultaneous;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
